// File: rtl/zero_normalizer_pkg.sv
// ============================================================================
// Module   : zero_normalizer_pkg
// Purpose  : Shared constants and stage payload for the left-normalizer and
//            the leading-zero counter that feeds it.
// Contents : ZN_WIDTH, ZN_CW  - default operand / count widths
//            zn_payload_t     - per-stage payload (data, count, zero)
// Config   : ZERO_NORMALIZER_CHECK_EN adds a 'lost' flag to the payload
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zero_normalizer_pkg;

  localparam int unsigned ZN_WIDTH = 32;
  localparam int unsigned ZN_CW    = $clog2(ZN_WIDTH);

  typedef struct packed {
    logic [ZN_WIDTH-1:0] data;
    logic [ZN_CW-1:0]    count;
    logic                zero;
`ifdef ZERO_NORMALIZER_CHECK_EN
    logic                lost;   // significant bits fell off the top in the shift
`endif
  } zn_payload_t;

endpackage

`default_nettype wire

// File: rtl/zero_normalizer_if.sv
// ============================================================================
// Module   : zero_normalizer_if
// Purpose  : Input and output valid/ready streams of the left-normalizer.
// Signals  : valid_i/ready_o/data_i/zcount_i/zero_i  - operand stream in
//            valid_o/ready_i/data_o/shamt_o/zero_o   - result stream out
// Modports : master - producer of operands / consumer of results
//            slave  - the normalizer itself
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zero_normalizer_if
  import zero_normalizer_pkg::*;
#(
  parameter int unsigned WIDTH = ZN_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH)
) ();

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic [CW-1:0]    zcount_i;
  logic             zero_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [CW-1:0]    shamt_o;
  logic             zero_o;

  modport master (
    output valid_i, data_i, zcount_i, zero_i, ready_i,
    input  ready_o, valid_o, data_o, shamt_o, zero_o
  );

  modport slave (
    input  valid_i, data_i, zcount_i, zero_i, ready_i,
    output ready_o, valid_o, data_o, shamt_o, zero_o
  );

endinterface

`default_nettype wire

// File: rtl/zero_normalizer_stage.sv
// ============================================================================
// Module   : zero_normalizer_stage
// Purpose  : One elastic pipeline slot: payload register plus valid bit.
//            Accepts a new payload whenever the slot is empty or is being
//            drained downstream in the same cycle.
// Ports    : clk, rst_n              - clock, async active-low reset
//            in_valid/in_ready/in_data   - upstream side
//            out_valid/out_ready/out_data - downstream side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_normalizer_stage
  import zero_normalizer_pkg::*;
#(
  parameter type payload_t = zn_payload_t
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  // Ready depends only on downstream state, never on in_valid.
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      // Bubbles leave the payload untouched to avoid needless toggling.
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/zero_normalizer.sv
// ============================================================================
// Module   : zero_normalizer
// Purpose  : Two-stage pipelined left-normalizer. Shifts the operand left by
//            its leading-zero count so the MSB becomes 1 and reports the
//            shift applied. Stage 1 does the coarse shift (multiples of 4),
//            stage 2 the fine shift (0..3) into the output register.
// Ports    : clk_i, rstn_i - clock, async active-low reset
//            bus           - zero_normalizer_if.slave (operand/result streams)
//            err_o         - sticky consistency error (check build only)
// Config   : ZERO_NORMALIZER_CHECK_EN - builds err_o and its check logic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_normalizer
  import zero_normalizer_pkg::*;
#(
  parameter int unsigned WIDTH = ZN_WIDTH,
  localparam int unsigned CW   = $clog2(WIDTH)
) (
  input  logic clk_i,
  input  logic rstn_i,
`ifdef ZERO_NORMALIZER_CHECK_EN
  output logic err_o,
`endif
  zero_normalizer_if.slave bus
);

  // The stage payload type is sized by the package, so WIDTH must match it.
  if (WIDTH != ZN_WIDTH || WIDTH < 16) begin : g_width_check
    $error("zero_normalizer: WIDTH must equal ZN_WIDTH and be >= 16");
  end

  zn_payload_t   s1_in;
  zn_payload_t   s1_q;
  zn_payload_t   s2_in;
  zn_payload_t   s2_q;
  logic          s1_valid;
  logic          s2_ready;
  logic [CW-1:0] coarse_amt;

`ifdef ZERO_NORMALIZER_CHECK_EN
  logic [2*WIDTH-1:0] full_shift;
`endif

  // Stage 1: coarse shift by zcount[CW-1:2]*4. An all-zero operand carries
  // zero data and count so stage 2 needs no special case.
  always_comb begin
    coarse_amt  = {bus.zcount_i[CW-1:2], 2'b00};
    s1_in       = '0;
    s1_in.zero  = bus.zero_i;
    if (!bus.zero_i) begin
      s1_in.data  = bus.data_i << coarse_amt;
      s1_in.count = bus.zcount_i;
    end
`ifdef ZERO_NORMALIZER_CHECK_EN
    // Any set bit above WIDTH after the full shift is an over-count.
    full_shift = {{WIDTH{1'b0}}, bus.data_i} << bus.zcount_i;
    s1_in.lost = ~bus.zero_i & (|full_shift[2*WIDTH-1:WIDTH]);
`endif
  end

  zero_normalizer_stage #(
    .payload_t (zn_payload_t)
  ) u_s1 (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .in_valid  (bus.valid_i),
    .in_ready  (bus.ready_o),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  // Stage 2: fine shift by count[1:0].
  always_comb begin
    s2_in      = s1_q;
    s2_in.data = s1_q.data << s1_q.count[1:0];
  end

  zero_normalizer_stage #(
    .payload_t (zn_payload_t)
  ) u_s2 (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (bus.valid_o),
    .out_ready (bus.ready_i),
    .out_data  (s2_q)
  );

  assign bus.data_o  = s2_q.data;
  assign bus.shamt_o = s2_q.count;
  assign bus.zero_o  = s2_q.zero;

`ifdef ZERO_NORMALIZER_CHECK_EN
  logic err_q;
  logic beat_bad;

  // A non-zero result must be normalized and must not have lost bits.
  assign beat_bad = bus.valid_o & ~s2_q.zero & (~s2_q.data[WIDTH-1] | s2_q.lost);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= 1'b0;
    end else if (beat_bad) begin
      err_q <= 1'b1;
    end
  end

  // Flag on the offending beat itself, then hold until reset.
  assign err_o = err_q | beat_bad;
`endif

endmodule

`default_nettype wire

// File: tb/tb_zero_normalizer.sv
// ============================================================================
// Module   : tb_zero_normalizer
// Purpose  : Self-checking bench for zero_normalizer: directed vector table,
//            backpressure and mid-operation reset sequences, randomized
//            streaming against a queue-based reference model.
// Config   : ZERO_NORMALIZER_CHECK_EN - also exercises err_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_zero_normalizer;
  import zero_normalizer_pkg::*;

  localparam int W = 32;
  localparam int C = 5;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  zero_normalizer_if #(.WIDTH(W)) bus ();

`ifdef ZERO_NORMALIZER_CHECK_EN
  logic err_o;
`endif

  zero_normalizer #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
`ifdef ZERO_NORMALIZER_CHECK_EN
    .err_o  (err_o),
`endif
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result is the operand times 2^count, truncated to W bits.
  typedef struct packed {
    logic [W-1:0] data;
    logic [C-1:0] shamt;
    logic         zero;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] d, input logic [C-1:0] zc, input logic z);
    exp_t e;
    longint unsigned p;
    if (z) begin
      e = '{data: '0, shamt: '0, zero: 1'b1};
    end else begin
      p = longint'(d) * (longint'(1) << zc);
      e = '{data: p[W-1:0], shamt: zc, zero: 1'b0};
    end
    return e;
  endfunction

  // Scoreboard: every accepted operand is queued; every delivered result
  // must match the head. Queue depth is also the number of occupied slots.
  exp_t q[$];
  int   rx_count = 0;
  logic stall_prev = 1'b0;
  exp_t held;

  always @(negedge clk_i) begin
    exp_t e;
    exp_t cur;
    if (!rstn_i) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      cur = '{data: bus.data_o, shamt: bus.shamt_o, zero: bus.zero_o};
      if (stall_prev) begin
        check("stall_valid_hold", 64'(bus.valid_o), 64'd1);
        check("stall_payload_hold", 64'(cur), 64'(held));
      end
      check("ready_o_vs_occupancy", 64'(bus.ready_o), 64'((q.size() < 2) || bus.ready_i));
      if (bus.valid_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_beat: valid_o=1 data_o=0x%0h with no beat outstanding (t=%0t)",
                   bus.data_o, $time);
        end else if (bus.ready_i) begin
          e = q.pop_front();
          check("sb_data", 64'(bus.data_o), 64'(e.data));
          check("sb_shamt", 64'(bus.shamt_o), 64'(e.shamt));
          check("sb_zero", 64'(bus.zero_o), 64'(e.zero));
          rx_count++;
        end
      end
      stall_prev = bus.valid_o & ~bus.ready_i;
      held       = cur;
      if (bus.valid_i && bus.ready_o) begin
        q.push_back(model(bus.data_i, bus.zcount_i, bus.zero_i));
      end
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic [C-1:0] zc;
    logic         zero;
    logic [W-1:0] exp_data;
    logic [C-1:0] exp_shamt;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.zcount_i = '0;
    bus.zero_i   = 1'b0;
  endtask

  // Consistent random operand: pick the leading-zero count first.
  task automatic drive_random_beat();
    int lz;
    logic [W-1:0] top;
    lz = $urandom_range(0, W - 1);
    top = 32'h8000_0000 >> lz;
    bus.zero_i = ($urandom_range(0, 15) == 0);
    if (bus.zero_i) begin
      bus.data_i   = '0;
      bus.zcount_i = C'($urandom_range(0, W - 1));
    end else begin
      bus.data_i   = top | ($urandom() & (top - 1));
      bus.zcount_i = C'(lz);
    end
  endtask

  initial begin
    int idx;
    int rx0;
    logic acc;
    logic saw_full;
    logic [W-1:0] d;

    vecs[0] = '{32'h0000_1234, 5'd19, 1'b0, 32'h91A0_0000, 5'd19, 1'b0};
    vecs[1] = '{32'h8000_0000, 5'd0,  1'b0, 32'h8000_0000, 5'd0,  1'b0};
    vecs[2] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 5'd31, 1'b0};
    vecs[3] = '{32'h0000_0000, 5'd7,  1'b1, 32'h0000_0000, 5'd0,  1'b1};
    vecs[4] = '{32'h00FF_0000, 5'd8,  1'b0, 32'hFF00_0000, 5'd8,  1'b0};
    vecs[5] = '{32'h0000_0003, 5'd30, 1'b0, 32'hC000_0000, 5'd30, 1'b0};
    vecs[6] = '{32'h4000_0000, 5'd1,  1'b0, 32'h8000_0000, 5'd1,  1'b0};
    vecs[7] = '{32'h0001_8000, 5'd15, 1'b0, 32'hC000_0000, 5'd15, 1'b0};
    vecs[8] = '{32'h0000_0000, 5'd31, 1'b1, 32'h0000_0000, 5'd0,  1'b1};

    drive_idle();
    bus.ready_i = 1'b1;

    // Reset state
    #2;
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_data_o", 64'(bus.data_o), 64'd0);
    check("rst_shamt_o", 64'(bus.shamt_o), 64'd0);
    check("rst_zero_o", 64'(bus.zero_o), 64'd0);
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
`ifdef ZERO_NORMALIZER_CHECK_EN
    check("rst_err_o", 64'(err_o), 64'd0);
`endif

    // Directed table: single beats with exact two-cycle latency
    for (int i = 0; i < 9; i++) begin
      bus.valid_i  = 1'b1;
      bus.data_i   = vecs[i].data;
      bus.zcount_i = vecs[i].zc;
      bus.zero_i   = vecs[i].zero;
      tick();
      drive_idle();
      check($sformatf("vec%0d_lat1_valid", i), 64'(bus.valid_o), 64'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(bus.valid_o), 64'd1);
      check($sformatf("vec%0d_data", i), 64'(bus.data_o), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_shamt", i), 64'(bus.shamt_o), 64'(vecs[i].exp_shamt));
      check($sformatf("vec%0d_zero", i), 64'(bus.zero_o), 64'(vecs[i].exp_zero));
      tick();
    end

    // Streaming: 10 back-to-back beats, ready_i low for cycles 3..6
    idx      = 0;
    rx0      = rx_count;
    saw_full = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.ready_i = !(c >= 3 && c <= 6);
      if (idx < 10) begin
        bus.valid_i  = 1'b1;
        bus.data_i   = (32'h8000_0000 >> (3 * idx)) | 32'h1;
        bus.zcount_i = C'(3 * idx);
        bus.zero_i   = 1'b0;
      end else begin
        drive_idle();
      end
      @(negedge clk_i);
      acc = bus.valid_i & bus.ready_o;
      if (!bus.ready_o) saw_full = 1'b1;
      tick();
      if (acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd10);
    check("bp_all_received", 64'(rx_count - rx0), 64'd10);
    check("bp_ready_dropped", 64'(saw_full), 64'd1);

    // Reset with both stages full
    bus.ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.valid_i  = 1'b1;
      bus.data_i   = 32'h0F00_0000 >> i;
      bus.zcount_i = C'(4 + i);
      bus.zero_i   = 1'b0;
      tick();
    end
    drive_idle();
    check("full_valid_o", 64'(bus.valid_o), 64'd1);
    check("full_ready_o", 64'(bus.ready_o), 64'd0);
    #2;
    rstn_i = 1'b0;
    #1;
    check("midrst_valid_o", 64'(bus.valid_o), 64'd0);
    check("midrst_ready_o", 64'(bus.ready_o), 64'd1);
    check("midrst_data_o", 64'(bus.data_o), 64'd0);
    tick();
    tick();
    rstn_i      = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_no_beat", 64'(bus.valid_o), 64'd0);
    end
    rx0 = rx_count;
    bus.valid_i  = 1'b1;
    bus.data_i   = 32'h0000_00A5;
    bus.zcount_i = 5'd24;
    tick();
    drive_idle();
    tick();
    check("postrst_new_data", 64'(bus.data_o), 64'hA500_0000);
    tick();
    check("postrst_new_received", 64'(rx_count - rx0), 64'd1);

    // Randomized streaming against the reference model
    for (int c = 0; c < 600; c++) begin
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.valid_i = ($urandom_range(0, 2) != 0);
      drive_random_beat();
      tick();
    end
    drive_idle();
    bus.ready_i = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("drain_queue_empty", 64'(q.size()), 64'd0);
    check("drain_valid_o", 64'(bus.valid_o), 64'd0);

`ifdef ZERO_NORMALIZER_CHECK_EN
    check("err_clean_before", 64'(err_o), 64'd0);
    bus.valid_i  = 1'b1;
    bus.data_i   = 32'h0000_00F0;
    bus.zcount_i = 5'd26;
    tick();
    drive_idle();
    tick();
    check("err_beat_valid", 64'(bus.valid_o), 64'd1);
    check("err_on_beat", 64'(err_o), 64'd1);
    for (int c = 0; c < 3; c++) tick();
    check("err_sticky", 64'(err_o), 64'd1);
    rstn_i = 1'b0;
    #1;
    check("err_cleared_by_reset", 64'(err_o), 64'd0);
    tick();
    rstn_i = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zero_normalizer.md
Name: zero_normalizer

Overview:
- Pipelined left-normalizer in the crypto/bit-manipulation unit.
- Consumes the operand together with its leading-zero count (Z) and all-zero flag (V) from the leading-zero counter.
- Shifts the operand left so its MSB is 1, and returns the applied shift amount.
- Two-stage elastic pipeline with valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand width; power of two, >= 16.
- CW, $clog2(WIDTH), count width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rstn_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  input beat valid.
- ready_o  output  1  block accepts a beat this cycle.
- data_i  input  WIDTH  operand.
- zcount_i  input  CW  leading-zero count of data_i.
- zero_i  input  1  data_i is all zero; zcount_i is don't-care when set.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- data_o  output  WIDTH  normalized operand.
- shamt_o  output  CW  shift applied.
- zero_o  output  1  result is all zero.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Both stage valid bits clear.
  - valid_o=0, data_o=0, shamt_o=0, zero_o=0.
  - ready_o=1 once reset is deasserted.
- Stage 1 (capture on accept, valid_i & ready_o):
  - Shift data_i left by the upper count bits, zcount_i[CW-1:2] (coarse shift, multiples of 4).
  - Latch zcount_i and zero_i alongside.
- Stage 2 (registered outputs):
  - Shift the stage-1 data left by count[1:0].
  - Present data_o, shamt_o=count, zero_o.
- Latency: 2 cycles from accept to valid_o with no stall. Throughput: 1 beat/cycle.
- Handshake:
  - s2 advances when ~valid_o | ready_i.
  - s1 advances when ~s1_valid | s2 advance.
  - ready_o = s1 advance. Combinational only on ready_i, never on valid_i.
- Stall: while valid_o & ~ready_i, data_o/shamt_o/zero_o hold stable. No beat is lost or duplicated.
- zero_i=1: data_o=0, shamt_o=0, zero_o=1. The shift is suppressed regardless of zcount_i.
- zcount_i=0: pass-through. zcount_i=WIDTH-1: result is 1 at the MSB only.
- Simultaneous:
  - Output drain and input accept in the same cycle are permitted.
  - At steady state with ready_i=1, ready_o stays 1.
- Reset mid-operation: all in-flight beats are dropped. No output beat appears after reset deassertion until a new accept.
- Inconsistent input (count > true leading zeros): MSB bits are shifted out silently. This is legal and the result is not checked unless the optional feature is enabled.

Optional Feature:
- Macro: ZERO_NORMALIZER_CHECK_EN.
- With the macro:
  - Add output err_o (1 bit), reset 0.
  - err_o goes high on any output beat with zero_o=0 and data_o[WIDTH-1]=0, or with MSB bits lost in the shift.
  - err_o is sticky until reset.
- Without the macro: err_o is absent and no check logic is built.

Decomposition:
- Shared package:
  - Default WIDTH and CW constants.
  - A stage payload struct: data, count, zero.
  - Shared with the leading-zero counter and its wrapper.
- One natural sub-module: zero_normalizer_stage (payload register with valid/ready skid logic), instantiated twice.
- Shift logic stays in the top level.

Test Plan:
- data_i=0x0000_1234, zcount_i=19, zero_i=0, ready_i=1 -> two cycles later valid_o=1, data_o=0x91A0_0000, shamt_o=19, zero_o=0.
- data_i=0x8000_0000, zcount_i=0 -> data_o=0x8000_0000, shamt_o=0. Next, data_i=0x0000_0001, zcount_i=31 -> data_o=0x8000_0000, shamt_o=31.
- zero_i=1 with zcount_i=7, data_i=0 -> data_o=0, shamt_o=0, zero_o=1.
- Streaming with backpressure:
  - Stimulus: 10 back-to-back beats; ready_i held low for cycles 3-6.
  - Required: outputs are stable while stalled, ready_o drops once both stages are full, and all 10 results arrive in order with no loss or duplication.
- Reset mid-operation: assert rstn_i=0 with both stages full -> valid_o=0 immediately and stays 0 after release until a new beat is accepted.
- With ZERO_NORMALIZER_CHECK_EN: data_i=0x0000_00F0, zcount_i=26 -> err_o=1 on the output beat and stays 1 until reset.
